// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI slave controllers.
package spi_pkg;

  typedef enum logic {
    StIdle,
    StActive
  } spi_state_e;

  localparam logic        SPI_CLOCK_IDLE = 1'b1;
  localparam int unsigned SPI_BYTE_BITS  = 8;
  localparam int unsigned SPI_MAX_BYTES  = 4;
  localparam int unsigned SPI_WORD_BITS  = SPI_BYTE_BITS * SPI_MAX_BYTES;

  // Byte counts above SPI_MAX_BYTES saturate.
  function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

  // Left-align an n-byte word so the first byte to send sits in [31:24].
  function automatic logic [SPI_WORD_BITS-1:0] tx_align(input logic [SPI_WORD_BITS-1:0] data,
                                                        input logic [2:0]               n);
    logic [5:0] sh;
    sh = {3'd4 - n, 3'b000};
    return data << sh;
  endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Register/bus-side signals of the SPI slave: transmit load handshake and receive word.
interface spi_slave_ctrl_if;
  import spi_pkg::*;

  logic [SPI_WORD_BITS-1:0] tx_data;
  logic [2:0]               tx_bytes_valid;
  logic                     tx_load;
  logic                     tx_ready;
  logic [SPI_WORD_BITS-1:0] rx_data;
  logic [2:0]               rx_bytes_valid;
  logic                     rx_valid;
  logic                     busy;

  modport slave (
    input  tx_data, tx_bytes_valid, tx_load,
    output tx_ready, rx_data, rx_bytes_valid, rx_valid, busy
  );

  modport master (
    output tx_data, tx_bytes_valid, tx_load,
    input  tx_ready, rx_data, rx_bytes_valid, rx_valid, busy
  );

endinterface

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses on the synced value.
module spi_input_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  // No reset: the chain keeps tracking the pin through reset, so a pin that is
  // already low when reset releases does not produce a spurious edge.
  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[Stages-2:0], d_i};
    prev_q <= sync_q[Stages-1];
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI responder: samples MOSI on SCLK rise, shifts MISO on SCLK fall, all in the clk_i domain.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             spi_clk_i,
  input  logic             spi_cs_n_i,
  input  logic             spi_mosi_i,
  output logic             spi_miso_o,
  spi_slave_ctrl_if.slave  bus
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;
  logic unused_sclk, unused_cs, unused_mosi_rise, unused_mosi_fall;

  spi_input_sync #(.Stages(SYNC_STAGES)) u_sync_sclk (
    .clk_i  (clk_i),
    .d_i    (spi_clk_i),
    .q_o    (unused_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_input_sync #(.Stages(SYNC_STAGES)) u_sync_cs (
    .clk_i  (clk_i),
    .d_i    (spi_cs_n_i),
    .q_o    (unused_cs),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_input_sync #(.Stages(SYNC_STAGES)) u_sync_mosi (
    .clk_i  (clk_i),
    .d_i    (spi_mosi_i),
    .q_o    (mosi),
    .rise_o (unused_mosi_rise),
    .fall_o (unused_mosi_fall)
  );

  spi_state_e               state_q;
  logic [SPI_WORD_BITS-1:0] hold_data_q;
  logic [2:0]               hold_cnt_q;
  logic [7:0]               cur_byte_q;
  logic [SPI_WORD_BITS-1:0] rest_q;
  logic [2:0]               left_q;
  logic [2:0]               tx_bit_q;
  logic                     miso_q;
  logic                     pending_q;
  logic [7:0]               rx_byte_q;
  logic [2:0]               rx_bit_q;
  logic [2:0]               rx_idx_q;
  logic [SPI_WORD_BITS-1:0] rx_acc_q;
  logic [SPI_WORD_BITS-1:0] rx_data_q;
  logic [2:0]               rx_bv_q;
  logic                     rx_valid_q;

  logic [SPI_WORD_BITS-1:0] eff_data, aligned, acc_next;
  logic [2:0]               eff_cnt;
  logic [7:0]               first_byte, next_byte, rx_byte_next;

  // A load in the same cycle as CS fall wins over the holding register.
  always_comb begin
    eff_data     = bus.tx_load ? bus.tx_data : hold_data_q;
    eff_cnt      = bus.tx_load ? clamp_bytes(bus.tx_bytes_valid) : hold_cnt_q;
    aligned      = tx_align(eff_data, eff_cnt);
    first_byte   = (eff_cnt != 3'd0) ? aligned[31:24] : IDLE_FILL;
    next_byte    = (left_q != 3'd0) ? rest_q[31:24] : IDLE_FILL;
    rx_byte_next = {rx_byte_q[6:0], mosi};
    acc_next     = rx_acc_q;
    acc_next[{rx_idx_q[1:0], 3'b000} +: 8] = rx_byte_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      hold_data_q <= '0;
      hold_cnt_q  <= '0;
      cur_byte_q  <= '0;
      rest_q      <= '0;
      left_q      <= '0;
      tx_bit_q    <= '0;
      miso_q      <= 1'b1;
      pending_q   <= 1'b0;
      rx_byte_q   <= '0;
      rx_bit_q    <= '0;
      rx_idx_q    <= '0;
      rx_acc_q    <= '0;
      rx_data_q   <= '0;
      rx_bv_q     <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.tx_load) begin
            hold_data_q <= bus.tx_data;
            hold_cnt_q  <= clamp_bytes(bus.tx_bytes_valid);
          end
          if (cs_fall) begin
            state_q    <= StActive;
            cur_byte_q <= first_byte;
            miso_q     <= first_byte[7];
            rest_q     <= aligned << 8;
            left_q     <= (eff_cnt != 3'd0) ? eff_cnt - 3'd1 : 3'd0;
            tx_bit_q   <= 3'd7;
            pending_q  <= 1'b0;
            rx_bit_q   <= '0;
            rx_idx_q   <= '0;
          end
        end
        StActive: begin
          if (cs_rise) begin
            // Partial byte is dropped; the loaded word counts as consumed.
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            miso_q     <= 1'b1;
            if (rx_idx_q != 3'd0) begin
              rx_valid_q <= 1'b1;
              rx_data_q  <= rx_acc_q;
              rx_bv_q    <= rx_idx_q;
            end
          end else begin
            if (sclk_rise) begin
              rx_byte_q <= rx_byte_next;
              rx_bit_q  <= rx_bit_q + 3'd1;
              pending_q <= 1'b1;
              if (rx_bit_q == 3'd7) begin
                rx_acc_q <= acc_next;
                if (rx_idx_q == 3'd3) begin
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= acc_next;
                  rx_bv_q    <= 3'd4;
                  rx_idx_q   <= '0;
                end else begin
                  rx_idx_q <= rx_idx_q + 3'd1;
                end
              end
            end
            // Falls without a preceding rise (first edge after CS fall) are ignored.
            if (sclk_fall && pending_q) begin
              pending_q <= 1'b0;
              if (tx_bit_q != 3'd0) begin
                tx_bit_q <= tx_bit_q - 3'd1;
                miso_q   <= cur_byte_q[tx_bit_q - 3'd1];
              end else begin
                tx_bit_q   <= 3'd7;
                cur_byte_q <= next_byte;
                miso_q     <= next_byte[7];
                if (left_q != 3'd0) begin
                  rest_q <= rest_q << 8;
                  left_q <= left_q - 3'd1;
                end
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign spi_miso_o         = miso_q;
  assign bus.busy           = (state_q == StActive);
  assign bus.tx_ready       = (state_q == StIdle);
  assign bus.rx_data        = rx_data_q;
  assign bus.rx_bytes_valid = rx_bv_q;
  assign bus.rx_valid       = rx_valid_q;

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI responder (slave) that terminates the serial link driven by the team's SPI master controller. It recovers SPI clock, chip-select and MOSI in the system clock domain, shifts out up to four transmit bytes MSB-first, and assembles received bytes into a 32-bit word with a byte-valid count. It sits between an external SPI pin group and the register/bus side of the accelerator.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `spi_clk_i`, `spi_cs_n_i`, `spi_mosi_i` (≥2).
- `IDLE_FILL`, 8'hFF: byte sent on MISO once transmit bytes are exhausted.
- `clk_i` in 1: system clock; sole clock of the block.
- `rstn_i` in 1: reset, synchronous and active-low.
- `spi_clk_i` in 1: SPI clock from master; idles high.
- `spi_cs_n_i` in 1: chip select, active-low.
- `spi_mosi_i` in 1: serial data from master.
- `spi_miso_o` out 1: serial data to master; driven 1 when not selected.
- `tx_data_i` in 32: transmit word; byte `tx_bytes_valid_i-1` sent first, descending to byte 0.
- `tx_bytes_valid_i` in 3: number of valid transmit bytes, 0–4 (5–7 treated as 4).
- `tx_load_i` in 1: load strobe, accepted when `tx_ready_o`=1.
- `tx_ready_o` out 1: 1 while no transaction is active.
- `rx_data_o` out 32: received word; first received byte in [7:0], upward.
- `rx_bytes_valid_o` out 3: complete bytes in `rx_data_o`, 1–4.
- `rx_valid_o` out 1: one-cycle pulse; `rx_data_o`/`rx_bytes_valid_o` valid this cycle and held until next pulse.
- `busy_o` out 1: transaction active.

## Operation
- Inputs pass through `SYNC_STAGES` flops; one extra flop gives edge detect on synchronized SCLK and CS. MOSI sampled from its synchronized copy (same stage as SCLK).
- States: IDLE, ACTIVE. IDLE→ACTIVE on detected CS fall; ACTIVE→IDLE on detected CS rise. Any state→IDLE with outputs cleared on `rstn_i`=0.
- IDLE: `tx_load_i` captures `tx_data_i`/`tx_bytes_valid_i` into the tx holding register. Load and CS fall in the same cycle: the new data is used.
- CS fall: tx holding register copied to tx shift state; `spi_miso_o` drives MSB of first byte (or `IDLE_FILL` bit 7 if 0 bytes); bit counter=7, rx byte index=0.
- SCLK rising edge in ACTIVE: shift synchronized MOSI into rx byte register (MSB-first); set `pending`.
- SCLK falling edge in ACTIVE with `pending`=1: advance MISO to next bit, clear `pending`. Falling edges with `pending`=0 ignored (covers the first edge after CS fall).
- 8th rising edge of a byte: byte written to `rx_data_o` lane = byte index; index increments. At index 4 (word full): `rx_valid_o` pulse, `rx_bytes_valid_o`=4, index wraps to 0; next byte overwrites lane 0.
- After last tx byte, MISO sends `IDLE_FILL` repeatedly; tx side does not wrap.
- CS rise: partial byte (1–7 bits) discarded. If index>0, `rx_valid_o` pulse with `rx_bytes_valid_o`=index. tx holding register byte count cleared to 0 (word consumed); MISO→1.
- SCLK edges while CS high ignored.

## Timing
- Reset values: `spi_miso_o`=1, `tx_ready_o`=1, `busy_o`=0, `rx_valid_o`=0, `rx_data_o`=0, `rx_bytes_valid_o`=0, tx holding register 0.
- Pin-to-detect latency: `SYNC_STAGES`+1 cycles.
- MISO update: `SYNC_STAGES`+2 cycles after pin SCLK fall (registered output).
- `rx_valid_o`: `SYNC_STAGES`+2 cycles after the 32nd pin SCLK rise, or after pin CS rise.
- SCLK high and low phases must each be ≥ `SYNC_STAGES`+3 `clk_i` cycles; CS setup/hold to SCLK ≥ same.
- `tx_ready_o`/`busy_o` change the cycle after CS edge detect.

## Structure
- Package `spi_pkg`: state enum (IDLE, ACTIVE), `SPI_CLOCK_IDLE`=1, `SPI_BYTE_BITS`=8, `SPI_MAX_BYTES`=4. Shared with the master.
- Sub-module `spi_input_sync`: per-bit synchronizer plus rise/fall pulse outputs, instantiated for SCLK and CS; MOSI uses data output only.

## Test plan
- Load 32'hA1B2C3D4, 4 bytes; master sends 32 bits of 8'h11,22,33,44 → MISO reads A1,B2,C3,D4; one `rx_valid_o`, `rx_data_o`=32'h44332211, `rx_bytes_valid_o`=4.
- Load 2 bytes 16'hBEEF; 3-byte transaction → MISO BE,EF,FF; on CS rise `rx_bytes_valid_o`=3.
- CS rise after 13 bits → one byte reported, `rx_bytes_valid_o`=1; 5 partial bits dropped.
- 6-byte transaction → pulse at byte 4 (count 4), pulse at CS rise (count 2, lanes [15:0] new).
- `rstn_i` low mid-byte for 1 cycle → all outputs at reset values, no `rx_valid_o`; SCLK edges ignored until next CS fall.
- `tx_load_i` asserted while `busy_o`=1 → ignored; next transaction sends data from last accepted load or `IDLE_FILL` if consumed.
